// File: rtl/fifoid_rdsched.sv
// fifoid_rdsched: credit-based read scheduler between a multi-channel FIFO
// controller and a downstream consumer.
// - Picks one non-empty channel per cycle by round-robin and strobes a read.
// - Carries each read's channel id alongside the shared-memory read latency.
// - Lands {id, data} in a small output FIFO.
// - Credits bound the reads in flight plus the words buffered, so the output
//   FIFO can never overflow.
// Build option: define FIFOID_RDSCHED_PRIO0_EN to give channel 0 strict
// priority over the round-robin.
module fifoid_rdsched #(
    parameter int ADDCH = 7,
    parameter int NUMCH = 128,
    parameter int DW    = 32,
    parameter int RDLAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [NUMCH-1:0] ffnemp,
    output logic             ffrd,
    output logic [ADDCH-1:0] ffrdid,
    input  logic [DW-1:0]    rddata,
    output logic             ovalid,
    output logic [ADDCH-1:0] oid,
    output logic [DW-1:0]    odata,
    input  logic             oready
);

    localparam int OBD = RDLAT + 2;
    localparam int CW  = $clog2(OBD) + 1;
    localparam int PW  = $clog2(OBD);

    logic [ADDCH-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    credit_q, credit_d;

    logic [RDLAT-1:0] tag_vld_q, tag_vld_d;
    logic [ADDCH-1:0] tag_id_q [RDLAT];
    logic [ADDCH-1:0] tag_id_d [RDLAT];

    logic [ADDCH-1:0] buf_id_q   [OBD];
    logic [DW-1:0]    buf_data_q [OBD];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic             sel_found;
    logic [ADDCH-1:0] sel_id;
    logic [ADDCH-1:0] scan_id;
    logic             push;
    logic             pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OBD - 1)) ? '0 : p + PW'(1);
    endfunction

    // Round-robin search: first requesting channel strictly after the last grant.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        scan_id   = '0;
        for (int k = 1; k <= NUMCH; k++) begin
            scan_id = ADDCH'((int'(rr_ptr_q) + k) % NUMCH);
            if (!sel_found && ffnemp[scan_id]) begin
                sel_found = 1'b1;
                sel_id    = scan_id;
            end
        end
`ifdef FIFOID_RDSCHED_PRIO0_EN
        if (ffnemp[0]) begin
            sel_found = 1'b1;
            sel_id    = '0;
        end
`endif
    end

    // The read strobe is combinational so a grant costs no extra cycle; reset
    // gating keeps the FIFO controller quiet while the scheduler initialises.
    assign ffrd   = !rst && !flush && sel_found && (credit_q != '0);
    assign ffrdid = ffrd ? sel_id : '0;

    assign push   = tag_vld_q[RDLAT-1];
    assign ovalid = (count_q != '0);
    assign pop    = ovalid && oready;
    assign oid    = buf_id_q[rd_ptr_q];
    assign odata  = buf_data_q[rd_ptr_q];

    // Next-state for pointer, credits, tag pipeline and output FIFO bookkeeping.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        credit_d  = credit_q;
        tag_vld_d = '0;
        for (int i = 0; i < RDLAT; i++) begin
            tag_id_d[i] = '0;
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

`ifdef FIFOID_RDSCHED_PRIO0_EN
        // Channel-0 grants bypass the rotation, so they must not move it.
        if (ffrd && (ffrdid != '0)) begin
            rr_ptr_d = ffrdid;
        end
`else
        if (ffrd) begin
            rr_ptr_d = ffrdid;
        end
`endif

        tag_vld_d[0] = ffrd;
        tag_id_d[0]  = ffrdid;
        for (int i = 1; i < RDLAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end

        // ffrd already implies a nonzero credit, so only the upper bound needs a guard.
        if (ffrd && !pop) begin
            credit_d = credit_q - CW'(1);
        end else if (pop && !ffrd && (credit_q < CW'(OBD))) begin
            credit_d = credit_q + CW'(1);
        end

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        if (flush) begin
            tag_vld_d = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            credit_d  = CW'(OBD);
        end
    end

    // Control state register; reset leaves the pointer so channel 0 is granted first.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= ADDCH'(NUMCH - 1);
            credit_q  <= CW'(OBD);
            tag_vld_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            credit_q  <= credit_d;
            tag_vld_q <= tag_vld_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Datapath storage; only the valid bits and counters need resetting.
    always_ff @(posedge clk) begin
        tag_id_q <= tag_id_d;
        if (push && !flush) begin
            buf_id_q[wr_ptr_q]   <= tag_id_q[RDLAT-1];
            buf_data_q[wr_ptr_q] <= rddata;
        end
    end

endmodule

// File: tb/tb_fifoid_rdsched.sv
// Bench for fifoid_rdsched (NUMCH=8, RDLAT=2).
// - A table of vectors gives hand-derived expectations.
// - Hand sequences cover the single-word channel and reset in mid-operation.
// - A randomized phase runs against a queue-based reference model.
module tb_fifoid_rdsched;

    localparam int ADDCH = 3;
    localparam int NUMCH = 8;
    localparam int DW    = 32;
    localparam int RDLAT = 2;
    localparam int OBD   = RDLAT + 2;
`ifdef FIFOID_RDSCHED_PRIO0_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [NUMCH-1:0] ffnemp;
    logic             ffrd;
    logic [ADDCH-1:0] ffrdid;
    logic [DW-1:0]    rddata;
    logic             ovalid;
    logic [ADDCH-1:0] oid;
    logic [DW-1:0]    odata;
    logic             oready;

    always #5 clk = ~clk;

    fifoid_rdsched #(.ADDCH(ADDCH), .NUMCH(NUMCH), .DW(DW), .RDLAT(RDLAT)) dut (
        .clk(clk), .rst(rst), .flush(flush), .ffnemp(ffnemp),
        .ffrd(ffrd), .ffrdid(ffrdid), .rddata(rddata),
        .ovalid(ovalid), .oid(oid), .odata(odata), .oready(oready)
    );

    typedef struct {
        logic [ADDCH-1:0] id;
        logic [DW-1:0]    data;
        int               cyc;
    } word_t;

    typedef struct {
        logic             r;
        logic             f;
        logic             o;
        logic [NUMCH-1:0] mask;
        logic             x_ffrd;
        logic [ADDCH-1:0] x_id;
        logic             x_ov;
        logic [ADDCH-1:0] x_oid;
    } vec_t;

    word_t exp_q[$];
    vec_t  tbl[$];
    int    cnt[NUMCH];
    int    credit;
    int    rr_last;
    int    cyc;
    int    vectors;
    int    miscompares;
    logic [DW-1:0] memd [RDLAT];

    logic             s_ffrd, s_ovalid;
    logic [ADDCH-1:0] s_id, s_oid;
    logic [DW-1:0]    s_odata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_pick(input logic [NUMCH-1:0] req);
        int c;
        if (PRIO && req[0]) return 0;
        for (int k = 1; k <= NUMCH; k++) begin
            c = (rr_last + k) % NUMCH;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [ADDCH-1:0] pid(input int n);
        return PRIO ? '0 : ADDCH'(n);
    endfunction

    task automatic run_cycle(input logic r, input logic f, input logic o);
        logic [NUMCH-1:0] nemp;
        logic             m_ffrd, m_ov;
        logic [ADDCH-1:0] m_id;
        logic [DW-1:0]    newdata;
        word_t            w;
        int               p;
        for (int c = 0; c < NUMCH; c++) nemp[c] = (cnt[c] > 0);
        rst    = r;
        flush  = f;
        oready = o;
        ffnemp = nemp;
        p      = model_pick(nemp);
        m_ffrd = !r && !f && (p >= 0) && (credit > 0);
        m_id   = m_ffrd ? ADDCH'(p) : '0;
        m_ov   = (exp_q.size() > 0) && (exp_q[0].cyc + RDLAT + 1 <= cyc);
        newdata = $urandom;
        @(negedge clk);
        s_ffrd   = ffrd;
        s_id     = ffrdid;
        s_ovalid = ovalid;
        s_oid    = oid;
        s_odata  = odata;
        if (!r) begin
            check("ffrd", s_ffrd, m_ffrd);
            check("ffrdid", s_id, m_id);
            check("ovalid", s_ovalid, m_ov);
            if (m_ov) begin
                check("oid", s_oid, exp_q[0].id);
                check("odata", s_odata, exp_q[0].data);
            end
        end
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            credit  = OBD;
            rr_last = NUMCH - 1;
        end else begin
            if (m_ov && o) begin
                void'(exp_q.pop_front());
                credit++;
            end
            if (m_ffrd) begin
                w.id = m_id; w.data = newdata; w.cyc = cyc;
                exp_q.push_back(w);
                credit--;
                cnt[p]--;
                if (!(PRIO && p == 0)) rr_last = p;
            end
            if (f) begin
                exp_q.delete();
                credit = OBD;
            end
        end
        for (int i = RDLAT - 1; i > 0; i--) memd[i] = memd[i-1];
        memd[0] = m_ffrd ? newdata : DW'($urandom);
        cyc++;
        #1;
        rddata = memd[RDLAT-1];
    endtask

    task automatic add(input logic r, input logic f, input logic o, input logic [NUMCH-1:0] m,
                       input logic xf, input logic [ADDCH-1:0] xid,
                       input logic xov, input logic [ADDCH-1:0] xoid);
        vec_t v;
        v.r = r; v.f = f; v.o = o; v.mask = m;
        v.x_ffrd = xf; v.x_id = xid; v.x_ov = xov; v.x_oid = xoid;
        tbl.push_back(v);
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        credit = OBD; rr_last = NUMCH - 1;
        rst = 1'b1; flush = 1'b0; oready = 1'b0; ffnemp = '0; rddata = '0;
        for (int i = 0; i < RDLAT; i++) memd[i] = '0;
        for (int c = 0; c < NUMCH; c++) cnt[c] = 0;

        // idle after reset, then steady 0x0A
        add(1,0,1,8'h00, 0,0,0,0);
        add(0,0,1,8'h00, 0,0,0,0);
        add(0,0,1,8'h00, 0,0,0,0);
        add(0,0,1,8'h00, 0,0,0,0);
        add(0,0,1,8'h0A, 1,1,0,0);
        add(0,0,1,8'h0A, 1,3,0,0);
        add(0,0,1,8'h0A, 1,1,0,0);
        add(0,0,1,8'h0A, 1,3,1,1);
        add(0,0,1,8'h0A, 1,1,1,3);
        add(0,0,1,8'h0A, 1,3,1,1);
        // credit exhaustion with downstream stalled, then release
        add(1,0,0,8'hFF, 0,0,0,0);
        add(0,0,0,8'hFF, 1,pid(0),0,0);
        add(0,0,0,8'hFF, 1,pid(1),0,0);
        add(0,0,0,8'hFF, 1,pid(2),0,0);
        add(0,0,0,8'hFF, 1,pid(3),1,pid(0));
        add(0,0,0,8'hFF, 0,0,1,pid(0));
        add(0,0,0,8'hFF, 0,0,1,pid(0));
        add(0,0,1,8'hFF, 0,0,1,pid(0));
        add(0,0,1,8'hFF, 1,pid(4),1,pid(1));
        add(0,0,1,8'hFF, 1,pid(5),1,pid(2));
        add(0,0,1,8'hFF, 1,pid(6),1,pid(3));
        add(0,0,1,8'hFF, 1,pid(7),1,pid(4));
        // flush with three words buffered, then full credit restored
        add(1,0,0,8'hFE, 0,0,0,0);
        add(0,0,0,8'hFE, 1,1,0,0);
        add(0,0,0,8'hFE, 1,2,0,0);
        add(0,0,0,8'hFE, 1,3,0,0);
        add(0,0,0,8'h00, 0,0,1,1);
        add(0,0,0,8'h00, 0,0,1,1);
        add(0,1,0,8'hFE, 0,0,1,1);
        add(0,0,1,8'h00, 0,0,0,0);
        add(0,0,1,8'h00, 0,0,0,0);
        add(0,0,0,8'hFE, 1,4,0,0);
        add(0,0,0,8'hFE, 1,5,0,0);
        add(0,0,0,8'hFE, 1,6,0,0);
        add(0,0,0,8'hFE, 1,7,1,4);
        add(0,0,0,8'hFE, 0,0,1,4);
        // full rotation (all zeros with channel-0 priority)
        add(1,0,1,8'hFF, 0,0,0,0);
        add(0,0,1,8'hFF, 1,pid(0),0,0);
        add(0,0,1,8'hFF, 1,pid(1),0,0);
        add(0,0,1,8'hFF, 1,pid(2),0,0);
        add(0,0,1,8'hFF, 1,pid(3),1,pid(0));
        add(0,0,1,8'hFF, 1,pid(4),1,pid(1));
        add(0,0,1,8'hFF, 1,pid(5),1,pid(2));
        add(0,0,1,8'hFF, 1,pid(6),1,pid(3));
        add(0,0,1,8'hFF, 1,pid(7),1,pid(4));
        add(0,0,1,8'hFF, 1,pid(0),1,pid(5));

        for (int i = 0; i < tbl.size(); i++) begin
            for (int c = 0; c < NUMCH; c++) cnt[c] = (!tbl[i].r && tbl[i].mask[c]) ? 1000 : 0;
            run_cycle(tbl[i].r, tbl[i].f, tbl[i].o);
            if (!tbl[i].r) begin
                check($sformatf("tbl%0d_ffrd", i), s_ffrd, tbl[i].x_ffrd);
                check($sformatf("tbl%0d_ffrdid", i), s_id, tbl[i].x_id);
                check($sformatf("tbl%0d_ovalid", i), s_ovalid, tbl[i].x_ov);
                if (tbl[i].x_ov) check($sformatf("tbl%0d_oid", i), s_oid, tbl[i].x_oid);
            end
        end

        // channel 5 holds a single word: exactly one read of it
        for (int c = 0; c < NUMCH; c++) cnt[c] = 0;
        run_cycle(1'b1, 1'b0, 1'b1);
        cnt[5] = 1;
        run_cycle(1'b0, 1'b0, 1'b1);
        check("one_word_ffrd", s_ffrd, 1'b1);
        check("one_word_id", s_id, 3'd5);
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b0, 1'b0, 1'b1);
            check("one_word_no_reread", s_ffrd, 1'b0);
        end
        check("one_word_ovalid", s_ovalid, 1'b1);
        check("one_word_oid", s_oid, 3'd5);
        run_cycle(1'b0, 1'b0, 1'b1);
        check("one_word_drained", s_ovalid, 1'b0);

        // reset in the middle of traffic discards in-flight words
        for (int c = 0; c < NUMCH; c++) cnt[c] = 1000;
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 1'b0);
        run_cycle(1'b1, 1'b0, 1'b1);
        for (int c = 0; c < NUMCH; c++) cnt[c] = 0;
        for (int i = 0; i < 5; i++) begin
            run_cycle(1'b0, 1'b0, 1'b1);
            check("rst_mid_ovalid", s_ovalid, 1'b0);
        end

        // randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                int ch;
                ch = int'($urandom_range(0, NUMCH - 1));
                cnt[ch] += int'($urandom_range(1, 3));
            end
            run_cycle($urandom_range(0, 499) == 0,
                      $urandom_range(0, 79) == 0,
                      $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
